// File: rtl/baby_beat_sequencer.sv
// baby_beat_sequencer: beat timing FSM (SCAN1/ACTION1/SCAN2/ACTION2) driving a ttl191 digit counter.
// Optional instruction counter enabled by defining BABY_SEQ_INSTR_COUNT_EN.
module baby_beat_sequencer #(
  parameter int DIGIT_WIDTH     = 5,
  parameter int DIGITS_PER_BEAT = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [DIGIT_WIDTH-1:0] CNT_Q,
  input  logic                   START,
  input  logic                   STEP,
  input  logic                   RUN,
  input  logic                   STOP_REQ,
  output logic                   LOAD_n,
  output logic                   CTEN_n,
  output logic [DIGIT_WIDTH-1:0] PRESET,
  output logic [1:0]             BEAT,
  output logic                   SCAN,
  output logic                   ACTION,
  output logic                   BEAT_START,
  output logic                   STOP_LAMP,
  output logic [15:0]            INSTR_COUNT
);
  typedef enum logic [2:0] {STOPPED, SCAN1, ACTION1, SCAN2, ACTION2} state_t;
  localparam logic [DIGIT_WIDTH-1:0] TC = DIGIT_WIDTH'(DIGITS_PER_BEAT - 1);
  state_t state, state_n;
  logic   pending, pend_n, step_mode, step_n, stopped, tc;
  assign stopped = (state == STOPPED);
  // >= rather than == so a counter that powers up out of range still ends the beat
  assign tc = !stopped && (CNT_Q >= TC);
  assign CTEN_n = stopped;
  assign LOAD_n = ~(stopped | tc);
  assign PRESET = '0;
  assign STOP_LAMP = stopped;
  assign BEAT = {state == SCAN2 || state == ACTION2, state == ACTION1 || state == ACTION2};
  assign SCAN = state == SCAN1 || state == SCAN2;
  assign ACTION = state == ACTION1 || state == ACTION2;
  always_comb begin
    state_n = state;
    step_n = step_mode;
    pend_n = pending;
    if (stopped) begin
      if (STEP || (START && RUN)) begin
        state_n = SCAN1;
        step_n = STEP;
        pend_n = 1'b0;
      end
    end else begin
      pend_n = pending | ~RUN | step_mode | (state == ACTION1 && STOP_REQ);
      if (tc)
        state_n = state == SCAN1 ? ACTION1 : state == ACTION1 ? SCAN2 :
                  state == SCAN2 ? ACTION2 : pend_n ? STOPPED : SCAN1;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= STOPPED;
      pending <= 1'b0;
      step_mode <= 1'b0;
      BEAT_START <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pend_n;
      step_mode <= step_n;
      BEAT_START <= (state_n != state) && (state_n != STOPPED);
    end
  end
`ifdef BABY_SEQ_INSTR_COUNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) INSTR_COUNT <= '0;
    else if (state == ACTION2 && tc && INSTR_COUNT != 16'hFFFF) INSTR_COUNT <= INSTR_COUNT + 16'd1;
  end
`else
  assign INSTR_COUNT = 16'h0000;
`endif
endmodule

// File: tb/tb_baby_beat_sequencer.sv
// tb_baby_beat_sequencer: directed bench with a behavioural 4-bit ttl191 counter in the loop.
module tb_baby_beat_sequencer;
  logic       CLK = 0, RESET = 1, START = 0, STEP = 0, RUN = 0, STOP_REQ = 0;
  logic [3:0] CNT_Q, PRESET;
  logic       LOAD_n, CTEN_n, SCAN, ACTION, BEAT_START, STOP_LAMP;
  logic [1:0] BEAT;
  logic [15:0] INSTR_COUNT;
  int n_cmp = 0, n_bad = 0, n_instr = 0;
  baby_beat_sequencer #(.DIGIT_WIDTH(4), .DIGITS_PER_BEAT(4)) dut (
    .CLK(CLK), .RESET(RESET), .CNT_Q(CNT_Q), .START(START), .STEP(STEP), .RUN(RUN),
    .STOP_REQ(STOP_REQ), .LOAD_n(LOAD_n), .CTEN_n(CTEN_n), .PRESET(PRESET), .BEAT(BEAT),
    .SCAN(SCAN), .ACTION(ACTION), .BEAT_START(BEAT_START), .STOP_LAMP(STOP_LAMP),
    .INSTR_COUNT(INSTR_COUNT)
  );
  always #5 CLK = ~CLK;
  always_ff @(posedge CLK) begin
    if (!LOAD_n) CNT_Q <= PRESET;
    else if (!CTEN_n) CNT_Q <= CNT_Q + 4'd1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic expect_seq(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      int p = first + k;
      chk($sformatf("beat@%0d", p), BEAT, (p / 4) % 4);
      chk($sformatf("cnt@%0d", p), CNT_Q, p % 4);
      chk($sformatf("beat_start@%0d", p), BEAT_START, p % 4 == 0);
      chk($sformatf("scan@%0d", p), SCAN, ((p / 4) % 2) == 0);
      chk($sformatf("lamp@%0d", p), STOP_LAMP, 0);
      tick();
    end
  endtask
  task automatic expect_stopped(input string tag);
    chk({tag, "_lamp"}, STOP_LAMP, 1);
    chk({tag, "_beat"}, BEAT, 0);
    chk({tag, "_cten"}, CTEN_n, 1);
    chk({tag, "_load"}, LOAD_n, 0);
    chk({tag, "_cnt"}, CNT_Q, 0);
    chk({tag, "_action"}, ACTION, 0);
  endtask
  initial begin
    #1;
    chk("rst_lamp", STOP_LAMP, 1);
    chk("rst_load", LOAD_n, 0);
    chk("rst_cten", CTEN_n, 1);
    tick();
    chk("rst_cnt", CNT_Q, 0);
    chk("preset", PRESET, 0);
    RESET = 0;
    tick();
    expect_stopped("idle");
    RUN = 1; START = 1;
    tick();
    START = 0;
    expect_seq(0, 18);
    RUN = 0;
    expect_seq(18, 14);
    n_instr += 2;
    expect_stopped("rundrop");
    tick();
    expect_stopped("rundrop_hold");
    RUN = 1; STEP = 1;
    tick();
    STEP = 0;
    expect_seq(0, 16);
    n_instr += 1;
    expect_stopped("step");
    tick();
    expect_stopped("step_hold");
    START = 1;
    tick();
    START = 0;
    expect_seq(0, 5);
    STOP_REQ = 1;
    tick();
    STOP_REQ = 0;
    expect_seq(6, 10);
    n_instr += 1;
    expect_stopped("stopreq");
    RUN = 0; START = 1;
    tick();
    START = 0;
    expect_stopped("start_norun");
    tick();
    expect_stopped("start_norun2");
    RUN = 1; START = 1; STEP = 1;
    tick();
    START = 0; STEP = 0;
    expect_seq(0, 16);
    n_instr += 1;
    expect_stopped("start_step");
`ifdef BABY_SEQ_INSTR_COUNT_EN
    chk("instr_count", INSTR_COUNT, n_instr);
`else
    chk("instr_count", INSTR_COUNT, 0);
`endif
    START = 1;
    tick();
    START = 0;
    expect_seq(0, 6);
    RESET = 1;
    #1;
    expect_stopped_nocnt();
    tick();
    chk("midrst_cnt", CNT_Q, 0);
    RESET = 0;
    tick();
    expect_stopped("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  task automatic expect_stopped_nocnt();
    chk("midrst_lamp", STOP_LAMP, 1);
    chk("midrst_beat", BEAT, 0);
    chk("midrst_cten", CTEN_n, 1);
    chk("midrst_load", LOAD_n, 0);
    chk("midrst_bs", BEAT_START, 0);
    chk("midrst_scan", SCAN, 0);
    chk("midrst_ic", INSTR_COUNT, 0);
  endtask
endmodule
